lsio_bus_master: RTL and testbench
==================================

Name: lsio_bus_master

Overview:
Initiator side of the LSIO peripheral bus: converts CPU load/store requests into single bus beats.
- Outputs: enable, wstrb, addr, addr_prev, wvalue.
- Reads: samples rvalue one cycle after the beat.
- Handles byte/half/word sizing, lane placement, sign extension and misalignment errors.
- Sits between the core's memory stage and the LSIO/peripheral responders.

Parameters:
ERR_ON_MISALIGN, 1, 1 = misaligned access returns error without a bus beat; 0 = force-align address (clear low bits) and perform the access.
READ_STROBE, 4'h0, wstrb_o value driven on a read beat.

Ports:
clk_i  in  1  clock
rstn_i  in  1  synchronous active-low reset
req_valid_i  in  1  CPU request valid
req_ready_o  out  1  master can accept request
req_we_i  in  1  1 = store, 0 = load
req_size_i  in  2  0 byte, 1 half, 2 word, 3 illegal
req_unsigned_i  in  1  load zero-extends when 1
req_addr_i  in  32  byte address
req_wdata_i  in  32  store data, LSB-aligned
resp_valid_o  out  1  response valid
resp_ready_i  in  1  CPU accepts response
resp_rdata_o  out  32  load data, extended; 0 for stores/errors
resp_err_o  out  1  misaligned or illegal-size request
enable_o  out  1  bus beat strobe
wstrb_o  out  4  byte write mask; READ_STROBE on reads
addr_o  out  32  beat address, word-aligned
addr_prev_o  out  32  addr_o delayed one cycle
wvalue_o  out  32  lane-replicated store data
rvalue_i  in  32  read data, valid the cycle after a read beat

Behaviour:
- Reset (synchronous, rstn_i low at posedge):
  - state=IDLE.
  - enable_o=0, wstrb_o=0, addr_o=0, addr_prev_o=0, wvalue_o=0.
  - resp_valid_o=0, resp_rdata_o=0, resp_err_o=0.
  - req_ready_o=1 once the reset state is entered.
- Reset mid-operation: in-flight request is dropped, no response issued, no further beat issued.
- req_ready_o = (state==IDLE), combinational from state only.
- All bus outputs are registered. addr_prev_o <= addr_o every cycle, unconditionally.
- States: IDLE, ISSUE, RD_CAP, RESP.
- IDLE: on req_valid_i in cycle N, latch the request.
  - If the request is in error: go to RESP with resp_err_o=1, resp_valid_o=1 at N+1, and no beat. A request is in error when size==3, or when ERR_ON_MISALIGN=1 and the access is misaligned (half with addr[0]=1; word with addr[1:0]!=0).
  - Otherwise go to ISSUE.
- ISSUE (cycle N+1): enable_o=1 for exactly this cycle, addr_o={addr[31:2],2'b00}.
  - Store:
    - wstrb_o: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'hf.
    - wvalue_o: byte {4{d[7:0]}}; half {2{d[15:0]}}; word d.
    - Next state RESP; resp_valid_o=1 at N+2.
  - Load: wstrb_o=READ_STROBE, wvalue_o=0. Next state RD_CAP.
- RD_CAP (cycle N+2): enable_o=0; addr_prev_o equals the beat address.
  - Sample rvalue_i and shift right by 8*addr[1:0].
  - Extend: byte bit 7, half bit 15, or zero-extend if req_unsigned_i was 1; word unchanged.
  - Next state RESP; resp_valid_o=1 at N+3.
- RESP: resp_valid_o, resp_rdata_o and resp_err_o are held stable until resp_ready_i=1, then IDLE in the next cycle.
  - resp_valid_o and resp_ready_i high in the same cycle with req_valid_i also high: the new request is not accepted until IDLE.
- Stores and errors: resp_rdata_o=0.
- Throughput: one request per 3 cycles (store) or 4 cycles (load) with resp_ready_i tied high.
- enable_o is never high in two consecutive cycles.

Decomposition:
- Package lsio_bus_pkg holds:
  - size_e {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL}
  - master state_e
  - LSIO register address constants: UART_TX 6'h0, UART_RX 6'h4, TIMER_MS 6'h8, BTN 6'hc
  - READ_STROBE default
- One combinational sub-module, lsio_lane_align:
  - store side: request → wstrb/wvalue
  - load side: rvalue/addr/size/unsigned → extended rdata
  - instantiated once, shared by ISSUE and RD_CAP.

Test Plan:
- Word store addr 0x1000_0000, data 0x0000_0041 → enable_o=1 for one cycle at N+1, wstrb_o=4'hf, addr_o=0x1000_0000, wvalue_o=0x41; resp_valid_o at N+2, rdata=0, err=0.
- Byte load addr 0x0000_0007, signed, rvalue_i=0x80FF_1234 → wstrb_o=4'h0, addr_o=0x4; at N+2 addr_prev_o=0x4; resp_rdata_o=0xFFFF_FF80. Same with unsigned → 0x0000_0080.
- Half store addr 0x2, data 0xABCD → wstrb_o=4'b1100, wvalue_o=0xABCD_ABCD.
- Word load addr 0x6 with ERR_ON_MISALIGN=1 → no enable_o pulse, resp_err_o=1, rdata=0 at N+1. With ERR_ON_MISALIGN=0 → beat at addr_o=0x4, err=0.
- resp_ready_i held low 5 cycles after a load → resp_valid_o and rdata stable all 5 cycles, req_ready_o=0, no extra beat; accepted on release, IDLE next cycle.
- rstn_i low during RD_CAP → next cycle all outputs 0, req_ready_o=1, no resp_valid_o for the dropped request.

Source files
------------

// File: rtl/lsio_bus_pkg.sv
// lsio_bus_pkg: shared types and constants for the LSIO bus master.
package lsio_bus_pkg;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL} size_e;
  typedef enum logic [1:0] {IDLE, ISSUE, RD_CAP, RESP} state_e;
  localparam logic [5:0] UART_TX = 6'h0;
  localparam logic [5:0] UART_RX = 6'h4;
  localparam logic [5:0] TIMER_MS = 6'h8;
  localparam logic [5:0] BTN = 6'hc;
  localparam logic [3:0] READ_STROBE_DEF = 4'h0;
  function automatic logic misaligned(size_e s, logic [1:0] a);
    return (s == SZ_HALF && a[0]) || (s == SZ_WORD && a != 2'b00);
  endfunction
endpackage

// File: rtl/lsio_lane_align.sv
// lsio_lane_align: byte-lane placement for stores and lane extraction/extension for loads.
module lsio_lane_align
  import lsio_bus_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rvalue,
  output logic [3:0]  wstrb,
  output logic [31:0] wvalue,
  output logic [31:0] rdata
);
  logic [31:0] sh;
  assign sh = rvalue >> {addr_lo, 3'b000};
  assign wstrb = size == SZ_BYTE ? 4'b0001 << addr_lo :
                 size == SZ_HALF ? 4'b0011 << {addr_lo[1], 1'b0} :
                 size == SZ_WORD ? 4'hf : 4'h0;
  assign wvalue = size == SZ_BYTE ? {4{wdata[7:0]}} :
                  size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
  assign rdata = size == SZ_BYTE ? {{24{sh[7] & ~is_unsigned}}, sh[7:0]} :
                 size == SZ_HALF ? {{16{sh[15] & ~is_unsigned}}, sh[15:0]} : sh;
endmodule

// File: rtl/lsio_bus_master.sv
// lsio_bus_master: turns CPU load/store requests into single LSIO bus beats.
module lsio_bus_master
  import lsio_bus_pkg::*;
#(
  parameter bit         ERR_ON_MISALIGN = 1'b1,
  parameter logic [3:0] READ_STROBE     = READ_STROBE_DEF
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        enable_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] addr_o,
  output logic [31:0] addr_prev_o,
  output logic [31:0] wvalue_o,
  input  logic [31:0] rvalue_i
);
  state_e      state;
  size_e       size_q;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  lo_q;
  size_e       req_size;
  logic        req_err;
  logic [1:0]  alo;
  logic [3:0]  a_wstrb;
  logic [31:0] a_wvalue;
  logic [31:0] a_rdata;
  assign req_size = size_e'(req_size_i);
  assign req_err = req_size == SZ_ILL || (ERR_ON_MISALIGN && misaligned(req_size, req_addr_i[1:0]));
  // force-aligned low bits; only reach the bus when misalignment is tolerated
  assign alo = req_size == SZ_WORD ? 2'b00 :
               req_size == SZ_HALF ? {req_addr_i[1], 1'b0} : req_addr_i[1:0];
  assign req_ready_o = state == IDLE;
  lsio_lane_align u_align (
    .size        (state == IDLE ? req_size : size_q),
    .addr_lo     (state == IDLE ? alo : lo_q),
    .is_unsigned (uns_q),
    .wdata       (req_wdata_i),
    .rvalue      (rvalue_i),
    .wstrb       (a_wstrb),
    .wvalue      (a_wvalue),
    .rdata       (a_rdata)
  );
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state        <= IDLE;
      size_q       <= SZ_BYTE;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      lo_q         <= 2'b00;
      enable_o     <= 1'b0;
      wstrb_o      <= 4'h0;
      addr_o       <= '0;
      addr_prev_o  <= '0;
      wvalue_o     <= '0;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
    end else begin
      addr_prev_o <= addr_o;
      enable_o    <= 1'b0;
      case (state)
        IDLE: if (req_valid_i) begin
          we_q   <= req_we_i;
          size_q <= req_size;
          uns_q  <= req_unsigned_i;
          lo_q   <= alo;
          if (req_err) begin
            state        <= RESP;
            resp_valid_o <= 1'b1;
            resp_err_o   <= 1'b1;
            resp_rdata_o <= '0;
          end else begin
            state    <= ISSUE;
            enable_o <= 1'b1;
            addr_o   <= {req_addr_i[31:2], 2'b00};
            wstrb_o  <= req_we_i ? a_wstrb : READ_STROBE;
            wvalue_o <= req_we_i ? a_wvalue : '0;
          end
        end
        ISSUE: begin
          state        <= we_q ? RESP : RD_CAP;
          resp_valid_o <= we_q;
          resp_rdata_o <= '0;
          resp_err_o   <= 1'b0;
        end
        RD_CAP: begin
          state        <= RESP;
          resp_valid_o <= 1'b1;
          resp_rdata_o <= a_rdata;
          resp_err_o   <= 1'b0;
        end
        RESP: if (resp_ready_i) begin
          state        <= IDLE;
          resp_valid_o <= 1'b0;
          resp_rdata_o <= '0;
          resp_err_o   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsio_bus_master.sv
// tb_lsio_bus_master: directed checks of the LSIO bus master, strict and force-align variants.
module tb_lsio_bus_master;
  logic clk_i = 1'b0;
  logic rstn_i = 1'b0;
  logic req_valid_i = 1'b0;
  logic req_we_i = 1'b0;
  logic [1:0] req_size_i = 2'd0;
  logic req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic resp_ready_i = 1'b1;
  logic [31:0] rvalue_i = '0;
  logic req_ready_o, resp_valid_o, resp_err_o, enable_o;
  logic [31:0] resp_rdata_o, addr_o, addr_prev_o, wvalue_o;
  logic [3:0] wstrb_o;
  logic req_ready_b, resp_valid_b, resp_err_b, enable_b;
  logic [31:0] resp_rdata_b, addr_b, addr_prev_b, wvalue_b;
  logic [3:0] wstrb_b;
  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  lsio_bus_master #(.ERR_ON_MISALIGN(1'b1), .READ_STROBE(4'h0)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .enable_o(enable_o), .wstrb_o(wstrb_o), .addr_o(addr_o), .addr_prev_o(addr_prev_o),
    .wvalue_o(wvalue_o), .rvalue_i(rvalue_i));

  lsio_bus_master #(.ERR_ON_MISALIGN(1'b0), .READ_STROBE(4'h0)) dut_b (
    .clk_i(clk_i), .rstn_i(rstn_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_b),
    .req_we_i(req_we_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .resp_valid_o(resp_valid_b),
    .resp_ready_i(resp_ready_i), .resp_rdata_o(resp_rdata_b), .resp_err_o(resp_err_b),
    .enable_o(enable_b), .wstrb_o(wstrb_b), .addr_o(addr_b), .addr_prev_o(addr_prev_b),
    .wvalue_o(wvalue_b), .rvalue_i(rvalue_i));

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic req(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata);
    req_valid_i = 1'b1;
    req_we_i = we;
    req_size_i = size;
    req_unsigned_i = uns;
    req_addr_i = addr;
    req_wdata_i = wdata;
    cyc();
    req_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    rstn_i = 1'b0;
    cyc(2);
    checks++;
    if ({enable_o, wstrb_o, addr_o, addr_prev_o, wvalue_o, resp_valid_o, resp_rdata_o, resp_err_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs en=%b strb=%h addr=%h prev=%h wv=%h rv=%b rd=%h err=%b want all zero",
               enable_o, wstrb_o, addr_o, addr_prev_o, wvalue_o, resp_valid_o, resp_rdata_o, resp_err_o);
    end
    checks++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready_o); end
    rstn_i = 1'b1;
    cyc();
  endtask

  task automatic test_word_store;
    req(1'b1, 2'd2, 1'b0, 32'h1000_0000, 32'h0000_0041);
    checks++;
    if ({enable_o, wstrb_o, addr_o, wvalue_o, resp_valid_o} !== {1'b1, 4'hf, 32'h1000_0000, 32'h41, 1'b0}) begin
      errors++;
      $display("FAIL word_store_beat en=%b strb=%h addr=%h wv=%h rv=%b want 1 f 10000000 00000041 0",
               enable_o, wstrb_o, addr_o, wvalue_o, resp_valid_o);
    end
    cyc();
    checks++;
    if ({enable_o, resp_valid_o, resp_rdata_o, resp_err_o, req_ready_o} !== {1'b0, 1'b1, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL word_store_resp en=%b rv=%b rd=%h err=%b rdy=%b want 0 1 0 0 0",
               enable_o, resp_valid_o, resp_rdata_o, resp_err_o, req_ready_o);
    end
    cyc();
    checks++;
    if ({req_ready_o, resp_valid_o} !== 2'b10) begin
      errors++;
      $display("FAIL word_store_idle rdy=%b rv=%b want 1 0", req_ready_o, resp_valid_o);
    end
  endtask

  task automatic test_byte_load(input logic uns, input logic [31:0] exp);
    rvalue_i = 32'h80FF_1234;
    req(1'b0, 2'd0, uns, 32'h0000_0007, 32'h0);
    checks++;
    if ({enable_o, wstrb_o, addr_o, wvalue_o} !== {1'b1, 4'h0, 32'h4, 32'h0}) begin
      errors++;
      $display("FAIL byte_load_beat uns=%b en=%b strb=%h addr=%h wv=%h want 1 0 00000004 0",
               uns, enable_o, wstrb_o, addr_o, wvalue_o);
    end
    cyc();
    checks++;
    if ({enable_o, addr_prev_o, resp_valid_o} !== {1'b0, 32'h4, 1'b0}) begin
      errors++;
      $display("FAIL byte_load_rdcap en=%b prev=%h rv=%b want 0 00000004 0", enable_o, addr_prev_o, resp_valid_o);
    end
    cyc();
    checks++;
    if ({resp_valid_o, resp_rdata_o, resp_err_o} !== {1'b1, exp, 1'b0}) begin
      errors++;
      $display("FAIL byte_load_resp uns=%b rv=%b rd=%h err=%b want 1 %h 0", uns, resp_valid_o, resp_rdata_o, resp_err_o, exp);
    end
    cyc();
  endtask

  task automatic test_half_store;
    req(1'b1, 2'd1, 1'b0, 32'h0000_0002, 32'h0000_ABCD);
    checks++;
    if ({enable_o, wstrb_o, addr_o, wvalue_o} !== {1'b1, 4'b1100, 32'h0, 32'hABCD_ABCD}) begin
      errors++;
      $display("FAIL half_store_beat en=%b strb=%b addr=%h wv=%h want 1 1100 0 abcdabcd",
               enable_o, wstrb_o, addr_o, wvalue_o);
    end
    cyc(2);
  endtask

  task automatic test_misalign;
    rvalue_i = 32'h1122_3344;
    req(1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0);
    checks++;
    if ({enable_o, resp_valid_o, resp_err_o, resp_rdata_o} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL misalign_err en=%b rv=%b err=%b rd=%h want 0 1 1 0", enable_o, resp_valid_o, resp_err_o, resp_rdata_o);
    end
    checks++;
    if ({enable_b, addr_b, wstrb_b} !== {1'b1, 32'h4, 4'h0}) begin
      errors++;
      $display("FAIL misalign_force_beat en=%b addr=%h strb=%h want 1 00000004 0", enable_b, addr_b, wstrb_b);
    end
    cyc();
    checks++;
    if ({enable_o, enable_b} !== 2'b00) begin
      errors++;
      $display("FAIL misalign_no_beat en=%b en_b=%b want 0 0", enable_o, enable_b);
    end
    cyc();
    checks++;
    if ({resp_valid_b, resp_err_b, resp_rdata_b} !== {1'b1, 1'b0, 32'h1122_3344}) begin
      errors++;
      $display("FAIL misalign_force_resp rv=%b err=%b rd=%h want 1 0 11223344", resp_valid_b, resp_err_b, resp_rdata_b);
    end
    cyc(2);
  endtask

  task automatic test_illegal_size;
    req(1'b1, 2'd3, 1'b0, 32'h0, 32'hFFFF_FFFF);
    checks++;
    if ({enable_o, resp_valid_o, resp_err_o, resp_rdata_o} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL illegal_size en=%b rv=%b err=%b rd=%h want 0 1 1 0", enable_o, resp_valid_o, resp_err_o, resp_rdata_o);
    end
    cyc(2);
  endtask

  task automatic test_back_to_back;
    logic [5:0] exp_en;
    exp_en = 6'b100100;
    req_valid_i = 1'b1;
    req_we_i = 1'b1;
    req_size_i = 2'd2;
    req_addr_i = 32'h0000_0010;
    req_wdata_i = 32'h5A5A_5A5A;
    for (int i = 5; i >= 0; i--) begin
      cyc();
      checks++;
      if (enable_o !== exp_en[i]) begin
        errors++;
        $display("FAIL back_to_back_en cycle=%0d got %b want %b", 5 - i, enable_o, exp_en[i]);
      end
    end
    req_valid_i = 1'b0;
    cyc(3);
  endtask

  task automatic test_stall;
    logic [31:0] held;
    rvalue_i = 32'hCAFE_BABE;
    resp_ready_i = 1'b0;
    req(1'b0, 2'd2, 1'b0, 32'h0000_0008, 32'h0);
    req_valid_i = 1'b1;
    cyc(2);
    held = 32'hCAFE_BABE;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({resp_valid_o, resp_rdata_o, req_ready_o, enable_o} !== {1'b1, held, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold cycle=%0d rv=%b rd=%h rdy=%b en=%b want 1 %h 0 0",
                 i, resp_valid_o, resp_rdata_o, req_ready_o, enable_o, held);
      end
      cyc();
    end
    resp_ready_i = 1'b1;
    cyc();
    req_valid_i = 1'b0;
    checks++;
    if ({resp_valid_o, req_ready_o, enable_o} !== 3'b010) begin
      errors++;
      $display("FAIL stall_release rv=%b rdy=%b en=%b want 0 1 0", resp_valid_o, req_ready_o, enable_o);
    end
    cyc(2);
  endtask

  task automatic test_reset_mid;
    req(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0);
    cyc();
    rstn_i = 1'b0;
    cyc();
    checks++;
    if ({enable_o, wstrb_o, addr_o, addr_prev_o, wvalue_o, resp_valid_o, resp_rdata_o, resp_err_o} !== '0
        || req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid en=%b addr=%h prev=%h rv=%b rd=%h rdy=%b want zeros and rdy 1",
               enable_o, addr_o, addr_prev_o, resp_valid_o, resp_rdata_o, req_ready_o);
    end
    rstn_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if ({resp_valid_o, enable_o} !== 2'b00) begin
        errors++;
        $display("FAIL reset_mid_dropped cycle=%0d rv=%b en=%b want 0 0", i, resp_valid_o, enable_o);
      end
    end
  endtask

  initial begin
    cyc();
    test_reset();
    test_word_store();
    test_byte_load(1'b0, 32'hFFFF_FF80);
    test_byte_load(1'b1, 32'h0000_0080);
    test_half_store();
    test_misalign();
    test_illegal_size();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
